ram16k_arbiter: RTL and testbench

- Two-port arbiter and sequencer that shares a single RAM16K (16-bit data, 14-bit address, synchronous write on load, combinational read) between requester A (CPU data port) and requester B (DMA/loader).
- Latches one request at a time and drives the RAM for exactly one cycle.
- Returns read data with a one-cycle acknowledge.
- Sits between the requesters and the RAM16K instance.

---
 rtl/ram16k_arbiter.sv | 114 +++++++++++
 tb/tb_ram16k_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram16k_arbiter.sv
// Two-requester arbiter that time-shares one RAM16K: one latched access per
// IDLE -> ACCESS -> DONE pass, with a one-cycle acknowledge to the owner.
module ram16k_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int AW          = 14,
  parameter int DW          = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          ack_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_b,
  output logic [DW-1:0] rdata_b,
  output logic [DW-1:0] ram_in,
  output logic          ram_load,
  output logic [AW-1:0] ram_address,
  input  logic [DW-1:0] ram_out,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state_q;
  logic            owner_b_q;
  logic            last_grant_b_q;
  logic            ram_load_q;
  logic [AW-1:0]   ram_address_q;
  logic [DW-1:0]   ram_in_q;
  logic            ack_a_q;
  logic            ack_b_q;
  logic [DW-1:0]   rdata_a_q;
  logic [DW-1:0]   rdata_b_q;
  logic            busy_q;
  logic            grant_b_d;

  // B wins when it is alone, or on a tie when round-robin says A went last.
  always_comb begin
    grant_b_d = req_b && (!req_a || ((ROUND_ROBIN != 0) && !last_grant_b_q));
  end

  // NOTE: every register, including the data holding registers, has an async
  // reset so an in-flight access is cancelled the instant reset_n falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      owner_b_q      <= 1'b0;
      last_grant_b_q <= 1'b1;
      ram_load_q     <= 1'b0;
      ram_address_q  <= '0;
      ram_in_q       <= '0;
      ack_a_q        <= 1'b0;
      ack_b_q        <= 1'b0;
      rdata_a_q      <= '0;
      rdata_b_q      <= '0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_a || req_b) begin
            owner_b_q     <= grant_b_d;
            ram_address_q <= grant_b_d ? addr_b  : addr_a;
            ram_in_q      <= grant_b_d ? wdata_b : wdata_a;
            ram_load_q    <= grant_b_d ? we_b    : we_a;
            busy_q        <= 1'b1;
            state_q       <= ACCESS;
          end
        end
        ACCESS: begin
          // The RAM write commits on this same edge, so load drops right after.
          if (!ram_load_q) begin
            if (owner_b_q) rdata_b_q <= ram_out;
            else           rdata_a_q <= ram_out;
          end
          ram_load_q     <= 1'b0;
          ack_a_q        <= !owner_b_q;
          ack_b_q        <= owner_b_q;
          last_grant_b_q <= owner_b_q;
          state_q        <= DONE;
        end
        DONE: begin
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ram_load_q <= 1'b0;
          ack_a_q    <= 1'b0;
          ack_b_q    <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign rdata_a     = rdata_a_q;
  assign rdata_b     = rdata_b_q;
  assign ram_load    = ram_load_q;
  assign ram_address = ram_address_q;
  assign ram_in      = ram_in_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Directed bench for ram16k_arbiter: a round-robin instance and a fixed-priority
// instance, each attached to its own behavioural RAM16K.
module tb_ram16k_arbiter;

  logic clk;
  logic reset_n;

  // Round-robin instance signals
  logic        req_a, we_a, req_b, we_b;
  logic [13:0] addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b;
  logic        ack_a, ack_b, ram_load, busy;
  logic [15:0] rdata_a, rdata_b, ram_in, ram_out;
  logic [13:0] ram_address;

  // Fixed-priority instance signals
  logic        f_req_a, f_we_a, f_req_b, f_we_b;
  logic [13:0] f_addr_a, f_addr_b;
  logic [15:0] f_wdata_a, f_wdata_b;
  logic        f_ack_a, f_ack_b, f_ram_load, f_busy;
  logic [15:0] f_rdata_a, f_rdata_b, f_ram_in, f_ram_out;
  logic [13:0] f_ram_address;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem   [0:16383];
  logic [15:0] f_mem [0:16383];

  ram16k_arbiter #(.ROUND_ROBIN(1), .AW(14), .DW(16)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rdata_b(rdata_b),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
    .ram_out(ram_out), .busy(busy)
  );

  ram16k_arbiter #(.ROUND_ROBIN(0), .AW(14), .DW(16)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .req_a(f_req_a), .we_a(f_we_a), .addr_a(f_addr_a), .wdata_a(f_wdata_a),
    .ack_a(f_ack_a), .rdata_a(f_rdata_a),
    .req_b(f_req_b), .we_b(f_we_b), .addr_b(f_addr_b), .wdata_b(f_wdata_b),
    .ack_b(f_ack_b), .rdata_b(f_rdata_b),
    .ram_in(f_ram_in), .ram_load(f_ram_load), .ram_address(f_ram_address),
    .ram_out(f_ram_out), .busy(f_busy)
  );

  // RAM16K models: synchronous write on load, combinational read.
  always @(posedge clk) if (ram_load)   mem[ram_address]     <= ram_in;
  always @(posedge clk) if (f_ram_load) f_mem[f_ram_address] <= f_ram_in;
  assign ram_out   = mem[ram_address];
  assign f_ram_out = f_mem[f_ram_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access on the round-robin instance, bounded wait for ack.
  task automatic xfer(input bit use_b, input logic w, input logic [13:0] a,
                      input logic [15:0] d, input string tag);
    int n;
    logic seen;
    if (use_b) begin
      we_b = w; addr_b = a; wdata_b = d; req_b = 1'b1;
    end else begin
      we_a = w; addr_a = a; wdata_a = d; req_a = 1'b1;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      cyc();
      n++;
      seen = use_b ? ack_b : ack_a;
    end
    check(tag, 32'(seen), 32'd1);
    if (use_b) req_b = 1'b0;
    else       req_a = 1'b0;
    cyc();
  endtask

  logic [11:0] exp_rr_a, exp_rr_b, exp_rr_busy, exp_fp_a;

  initial begin
    reset_n = 1'b0;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    f_req_a = 0; f_we_a = 0; f_addr_a = '0; f_wdata_a = '0;
    f_req_b = 0; f_we_b = 0; f_addr_b = '0; f_wdata_b = '0;
    exp_rr_a    = 12'b0000_1000_0010;
    exp_rr_b    = 12'b0100_0001_0000;
    exp_rr_busy = 12'b0110_1101_1011;
    exp_fp_a    = 12'b0100_1001_0010;

    // Reset state
    #12;
    check("rst_ram_load", 32'(ram_load), 0);
    check("rst_ram_addr", 32'(ram_address), 0);
    check("rst_ram_in", 32'(ram_in), 0);
    check("rst_ack", 32'({ack_a, ack_b}), 0);
    check("rst_rdata", 32'({rdata_a, rdata_b}), 0);
    check("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;

    // A writes F00D to 0x2A, then reads it back
    req_a = 1; we_a = 1; addr_a = 14'h002A; wdata_a = 16'hF00D;
    cyc();
    check("w1_access_load", 32'(ram_load), 1);
    check("w1_access_addr", 32'(ram_address), 32'h2A);
    check("w1_access_data", 32'(ram_in), 32'hF00D);
    check("w1_access_busy", 32'(busy), 1);
    check("w1_access_ack", 32'(ack_a), 0);
    cyc();
    check("w1_done_ack_a", 32'(ack_a), 1);
    check("w1_done_ack_b", 32'(ack_b), 0);
    check("w1_done_load", 32'(ram_load), 0);
    check("w1_done_rdata_held", 32'(rdata_a), 0);
    req_a = 0;
    cyc();
    check("w1_idle_ack", 32'(ack_a), 0);
    check("w1_idle_busy", 32'(busy), 0);
    req_a = 1; we_a = 0; addr_a = 14'h002A; wdata_a = 16'h0000;
    cyc();
    check("r1_access_load", 32'(ram_load), 0);
    cyc();
    check("r1_ack_a", 32'(ack_a), 1);
    check("r1_ack_b", 32'(ack_b), 0);
    check("r1_rdata_a", 32'(rdata_a), 32'hF00D);
    req_a = 0;
    cyc();
    check("r1_ack_drop", 32'(ack_a), 0);
    check("r1_rdata_hold", 32'(rdata_a), 32'hF00D);

    // Continuous contention after reset, round-robin and fixed priority
    reset_n = 0;
    #2;
    reset_n = 1;
    req_a = 1; we_a = 0; addr_a = 14'h0010;
    req_b = 1; we_b = 0; addr_b = 14'h0020;
    f_req_a = 1; f_we_a = 0; f_addr_a = 14'h0011;
    f_req_b = 1; f_we_b = 0; f_addr_b = 14'h0022;
    for (int k = 0; k < 12; k++) begin
      cyc();
      check($sformatf("rr_ack_a[%0d]", k), 32'(ack_a), 32'(exp_rr_a[k]));
      check($sformatf("rr_ack_b[%0d]", k), 32'(ack_b), 32'(exp_rr_b[k]));
      check($sformatf("rr_busy[%0d]", k), 32'(busy), 32'(exp_rr_busy[k]));
      check($sformatf("fp_ack_a[%0d]", k), 32'(f_ack_a), 32'(exp_fp_a[k]));
      check($sformatf("fp_ack_b[%0d]", k), 32'(f_ack_b), 0);
    end
    req_a = 0; req_b = 0;
    f_req_a = 0;
    cyc();
    check("fp_b_access_addr", 32'(f_ram_address), 32'h22);
    cyc();
    check("fp_b_ack_b", 32'(f_ack_b), 1);
    check("fp_b_ack_a", 32'(f_ack_a), 0);
    f_req_b = 0;
    cyc();

    // Same-cycle writes to address bounds; last grant was B so A goes first
    req_a = 1; we_a = 1; addr_a = 14'h0000; wdata_a = 16'h1234;
    req_b = 1; we_b = 1; addr_b = 14'h3FFF; wdata_b = 16'hABCD;
    cyc();
    check("bw_first_addr", 32'(ram_address), 32'h0000);
    cyc();
    check("bw_ack_a_first", 32'(ack_a), 1);
    check("bw_ack_b_wait", 32'(ack_b), 0);
    req_a = 0;
    cyc();
    cyc();
    check("bw_second_addr", 32'(ram_address), 32'h3FFF);
    check("bw_second_load", 32'(ram_load), 1);
    cyc();
    check("bw_ack_b", 32'(ack_b), 1);
    req_b = 0;
    cyc();
    xfer(1'b0, 1'b0, 14'h3FFF, 16'h0000, "xr_a_ack");
    check("xr_rdata_a", 32'(rdata_a), 32'hABCD);
    xfer(1'b1, 1'b0, 14'h0000, 16'h0000, "xr_b_ack");
    check("xr_rdata_b", 32'(rdata_b), 32'h1234);

    // Reset in the middle of an A write
    xfer(1'b0, 1'b1, 14'h0100, 16'h1111, "pre_w_ack");
    req_a = 1; we_a = 1; addr_a = 14'h0100; wdata_a = 16'hBEEF;
    cyc();
    check("abort_access_load", 32'(ram_load), 1);
    #2;
    reset_n = 0;
    req_a = 0;
    #1;
    check("abort_load_drop", 32'(ram_load), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_addr", 32'(ram_address), 0);
    check("abort_in", 32'(ram_in), 0);
    check("abort_rdata", 32'({rdata_a, rdata_b}), 0);
    check("abort_ack", 32'({ack_a, ack_b}), 0);
    cyc();
    check("abort_no_ack", 32'({ack_a, ack_b}), 0);
    reset_n = 1;
    xfer(1'b0, 1'b0, 14'h0100, 16'h0000, "abort_rd_ack");
    check("abort_rd_data", 32'(rdata_a), 32'h1111);

    // B address changes during ACCESS are ignored
    xfer(1'b1, 1'b1, 14'h0005, 16'h5A5A, "pre5_ack");
    xfer(1'b1, 1'b1, 14'h0006, 16'h6666, "pre6_ack");
    req_b = 1; we_b = 0; addr_b = 14'h0005;
    cyc();
    addr_b = 14'h0006;
    #1;
    check("hold_addr", 32'(ram_address), 32'h0005);
    cyc();
    check("hold_ack_b", 32'(ack_b), 1);
    check("hold_rdata_b", 32'(rdata_b), 32'h5A5A);
    req_b = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
